// File: rtl/mem_access.sv
// MA stage: issues loads/stores over req/gnt/rvalid, aligns load data, registers write-back.
// Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN traps misaligned H/W accesses in IDLE.
module mem_access #(
    parameter logic [7:0] DMEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_ld_ma,
    input  logic        cmd_st_ma,
    input  logic        wbk_rd_reg_ma,
    input  logic [4:0]  rd_adr_ma,
    input  logic [31:0] rd_data_ma,
    input  logic [31:0] st_data_ma,
    input  logic [2:0]  ldst_code_ma,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_adr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_ma,
    output logic        dmem_err,
    output logic        misalign_excep_ma,
    output logic        wbk_rd_reg_wb,
    output logic [4:0]  rd_adr_wb,
    output logic [31:0] rd_data_wb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  code_q, code_d;
    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;

    logic        wbk_wb_q, wbk_wb_d;
    logic [4:0]  rd_adr_wb_q, rd_adr_wb_d;
    logic [31:0] rd_data_wb_q, rd_data_wb_d;

    logic        is_mem;
    logic        misaligned;
    logic        timeout_hit;
    logic        abort;
    logic        ld_done;
    logic        stall;
    logic        trap;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] ld_data;

    function automatic logic [3:0] be_gen(
        input logic [1:0] lo,
        input logic [1:0] size
    );
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_gen(
        input logic [31:0] st,
        input logic [1:0]  size
    );
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{st[7:0]}};
            2'b01:   w = {2{st[15:0]}};
            default: w = st;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] ld_align(
        input logic [31:0] rdata,
        input logic [1:0]  lo,
        input logic [2:0]  code
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rdata[{lo, 3'b000} +: 8];
        h = rdata[{lo[1], 4'b0000} +: 16];
        case (code[1:0])
            2'b00:   res = code[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   res = code[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    assign is_mem      = cmd_ld_ma | cmd_st_ma;
    assign be_new      = be_gen(rd_data_ma[1:0], ldst_code_ma[1:0]);
    assign wdata_new   = lane_gen(st_data_ma, ldst_code_ma[1:0]);
    assign ld_data     = ld_align(dmem_rdata, adr_q[1:0], code_q);
    assign timeout_hit = (cnt_q == DMEM_TIMEOUT - 8'd1);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    // code 11 is treated as a word, so any set size[1] demands word alignment
    assign misaligned =
        ((ldst_code_ma[1:0] == 2'b01) & rd_data_ma[0]) |
        (ldst_code_ma[1] & (rd_data_ma[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        code_d  = code_q;
        we_d    = we_q;
        rd_d    = rd_q;
        stall   = 1'b0;
        abort   = 1'b0;
        ld_done = 1'b0;
        trap    = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    if (misaligned) begin
                        trap = 1'b1;
                    end else begin
                        state_d = REQ;
                        stall   = 1'b1;
                        cnt_d   = 8'd0;
                        adr_d   = rd_data_ma;
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        code_d  = ldst_code_ma;
                        we_d    = cmd_st_ma;
                        rd_d    = rd_adr_ma;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (we_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                        cnt_d   = 8'd0;
                        stall   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    ld_done = 1'b1;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // stall cycles emit a bubble; a pass-through only writes back outside memory ops
    always_comb begin
        wbk_wb_d     = 1'b0;
        rd_adr_wb_d  = rd_adr_ma;
        rd_data_wb_d = rd_data_ma;
        if (ld_done) begin
            wbk_wb_d     = 1'b1;
            rd_adr_wb_d  = rd_q;
            rd_data_wb_d = ld_data;
        end else if (state_q == IDLE) begin
            wbk_wb_d = wbk_rd_reg_ma & ~cmd_st_ma & ~stall & ~trap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            adr_q        <= 32'd0;
            be_q         <= 4'd0;
            wdata_q      <= 32'd0;
            code_q       <= 3'd0;
            we_q         <= 1'b0;
            rd_q         <= 5'd0;
            wbk_wb_q     <= 1'b0;
            rd_adr_wb_q  <= 5'd0;
            rd_data_wb_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            adr_q        <= adr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            code_q       <= code_d;
            we_q         <= we_d;
            rd_q         <= rd_d;
            wbk_wb_q     <= wbk_wb_d;
            rd_adr_wb_q  <= rd_adr_wb_d;
            rd_data_wb_q <= rd_data_wb_d;
        end
    end

    assign dmem_req          = (state_q == REQ);
    assign dmem_we           = dmem_req & we_q;
    assign dmem_adr          = dmem_req ? adr_q[31:2] : 30'd0;
    assign dmem_be           = dmem_req ? be_q : 4'd0;
    assign dmem_wdata        = dmem_req ? wdata_q : 32'd0;
    assign stall_ma          = stall;
    assign dmem_err          = abort;
    assign misalign_excep_ma = trap;
    assign wbk_rd_reg_wb     = wbk_wb_q;
    assign rd_adr_wb         = rd_adr_wb_q;
    assign rd_data_wb        = rd_data_wb_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: transaction-level model plus per-cycle output compare.
// Misalign expectations follow the MEM_ACCESS_MISALIGN_TRAP_EN build macro.
module tb_mem_access;

    localparam int T = 4;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_ld_ma = 1'b0;
    logic        cmd_st_ma = 1'b0;
    logic        wbk_rd_reg_ma = 1'b0;
    logic [4:0]  rd_adr_ma = 5'd0;
    logic [31:0] rd_data_ma = 32'd0;
    logic [31:0] st_data_ma = 32'd0;
    logic [2:0]  ldst_code_ma = 3'd0;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        stall_ma;
    logic        dmem_err;
    logic        misalign_excep_ma;
    logic        wbk_rd_reg_wb;
    logic [4:0]  rd_adr_wb;
    logic [31:0] rd_data_wb;

    int checks = 0;
    int failures = 0;

    bit          bus_on = 1'b0;
    bit          err_exp = 1'b0;
    bit          mis_exp = 1'b0;
    logic [29:0] exp_adr = '0;
    logic [3:0]  exp_be = '0;
    logic [31:0] exp_wdata = '0;
    bit          exp_we = 1'b0;
    logic [29:0] cap_adr = '0;
    logic [3:0]  cap_be = '0;
    logic [31:0] cap_wdata = '0;
    logic        cap_we = 1'b0;
    logic [36:0] wbq[$];

    mem_access #(.DMEM_TIMEOUT(8'(T))) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma),
        .wbk_rd_reg_ma(wbk_rd_reg_ma), .rd_adr_ma(rd_adr_ma),
        .rd_data_ma(rd_data_ma), .st_data_ma(st_data_ma),
        .ldst_code_ma(ldst_code_ma),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .stall_ma(stall_ma), .dmem_err(dmem_err),
        .misalign_excep_ma(misalign_excep_ma),
        .wbk_rd_reg_wb(wbk_rd_reg_wb), .rd_adr_wb(rd_adr_wb),
        .rd_data_wb(rd_data_wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [2:0] c, input logic [31:0] a);
        int lo;
        lo = int'(a[1:0]);
        if (c[1:0] == 2'b00) return 4'(1 << lo);
        if (c[1:0] == 2'b01) return (lo >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] c, input logic [31:0] d);
        longint b;
        longint h;
        b = longint'(d) % 256;
        h = longint'(d) % 65536;
        if (c[1:0] == 2'b00) return 32'(b * 32'h01010101);
        if (c[1:0] == 2'b01) return 32'(h * 65537);
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] c);
        longint v;
        if (c[1:0] == 2'b00) begin
            v = (longint'(w) >> (8 * int'(a[1:0]))) % 256;
            if (!c[2] && v >= 128) v = v - 256;
        end else if (c[1:0] == 2'b01) begin
            v = (longint'(w) >> (16 * int'(a[1]))) % 65536;
            if (!c[2] && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(w);
        end
        return v[31:0];
    endfunction

    function automatic bit m_mis(input logic [2:0] c, input logic [31:0] a);
        if (c[1:0] == 2'b01) return a[0];
        if (c[1:0] != 2'b00) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        logic [36:0] e;
        if (rst_n) begin
            chk("req", dmem_req, bus_on);
            if (dmem_req && bus_on) begin
                chk("adr", dmem_adr, exp_adr);
                chk("be", dmem_be, exp_be);
                chk("we", dmem_we, exp_we);
                if (exp_we) chk("wdata", dmem_wdata, exp_wdata);
                cap_adr   = dmem_adr;
                cap_be    = dmem_be;
                cap_wdata = dmem_wdata;
                cap_we    = dmem_we;
            end
            chk("err", dmem_err, err_exp);
            chk("misalign", misalign_excep_ma, mis_exp);
            if (wbk_rd_reg_wb) begin
                if (wbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected actual rd=%0d data=%h required=none",
                             rd_adr_wb, rd_data_wb);
                end else begin
                    e = wbq.pop_front();
                    chk("wb_rd", rd_adr_wb, e[36:32]);
                    chk("wb_data", rd_data_wb, e[31:0]);
                end
            end
        end
    end

    // gd/rvd: REQ/RESP wait cycles before gnt/rvalid; negative means never
    task automatic op(input bit ld, input bit st, input bit wbk, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] sd, input logic [2:0] code,
                      input int gd, input int rvd, input logic [31:0] rdat, input bit noise);
        bit mem;
        bit mis;
        bit abrt;
        bit rv;
        int ncyc;
        mem  = ld | st;
        mis  = TRAP && mem && m_mis(code, a);
        abrt = 1'b0;
        if (!mem || mis) ncyc = 1;
        else if (gd < 0) begin ncyc = 1 + T; abrt = 1'b1; end
        else if (st) ncyc = 2 + gd;
        else if (rvd < 0) begin ncyc = 2 + gd + T; abrt = 1'b1; end
        else ncyc = 3 + gd + rvd;
        cap_adr = '0; cap_be = '0; cap_wdata = '0; cap_we = 1'b0;
        for (int cyc = 0; ; cyc++) begin
            @(posedge clk); #1;
            cmd_ld_ma = ld; cmd_st_ma = st; wbk_rd_reg_ma = wbk;
            rd_adr_ma = rd; rd_data_ma = a; st_data_ma = sd; ldst_code_ma = code;
            exp_adr = a[31:2]; exp_be = m_be(code, a);
            exp_wdata = m_wdata(code, sd); exp_we = st;
            dmem_gnt = (mem && !mis && gd >= 0 && cyc == 1 + gd) || (noise && cyc == 0);
            rv = ld && !mis && gd >= 0 && rvd >= 0 && cyc == 2 + gd + rvd;
            dmem_rvalid = rv || (noise && cyc >= 1 && cyc <= gd);
            dmem_rdata = rv ? rdat : 32'hDEAD_BEEF;
            bus_on = mem && !mis && cyc >= 1 && ((gd < 0) ? cyc < ncyc : cyc <= 1 + gd);
            err_exp = abrt && cyc == ncyc - 1;
            mis_exp = mis && cyc == 0;
            @(negedge clk); #1;
            chk("stall", stall_ma, cyc < ncyc - 1);
            if (!stall_ma || cyc >= ncyc + 16) break;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; wbk_rd_reg_ma = 1'b0;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
            bus_on = 1'b0; err_exp = 1'b0; mis_exp = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [2:0]  c;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_adr", dmem_adr, 30'd0);
        chk("rst_be", dmem_be, 4'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_stall", stall_ma, 1'b0);
        chk("rst_err", dmem_err, 1'b0);
        chk("rst_mis", misalign_excep_ma, 1'b0);
        chk("rst_wbk", wbk_rd_reg_wb, 1'b0);
        chk("rst_rdadr", rd_adr_wb, 5'd0);
        chk("rst_rddata", rd_data_wb, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        op(0, 1, 1, 5'd3, 32'h100, 32'h12345678, 3'b010, 0, 0, 0, 0);
        chk("sw_be", cap_be, 4'hF);
        chk("sw_adr", cap_adr, 30'h40);
        chk("sw_we", cap_we, 1'b1);
        chk("sw_wdata", cap_wdata, 32'h12345678);

        wbq.push_back({5'd5, 32'hFFFF_FF80});
        op(1, 0, 1, 5'd5, 32'h103, 0, 3'b000, 0, 0, 32'h80FF_FFFF, 0);
        wbq.push_back({5'd5, 32'h0000_0080});
        op(1, 0, 1, 5'd5, 32'h103, 0, 3'b100, 0, 0, 32'h80FF_FFFF, 0);
        wbq.push_back({5'd9, 32'hFFFF_8001});
        op(1, 0, 1, 5'd9, 32'h102, 0, 3'b001, 0, 2, 32'h8001_1234, 0);

        op(0, 1, 0, 5'd0, 32'h101, 32'h0000_00AB, 3'b000, 0, 0, 0, 0);
        chk("sb_be", cap_be, 4'b0010);
        chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
        op(0, 1, 0, 5'd0, 32'h102, 32'h0000_BEEF, 3'b001, 1, 0, 0, 1);
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);

        wbq.push_back({5'd7, 32'hCAFE_F00D});
        op(0, 0, 1, 5'd7, 32'hCAFE_F00D, 0, 3'b000, 0, 0, 0, 0);
        op(0, 0, 0, 5'd8, 32'h1111_2222, 0, 3'b000, 0, 0, 0, 0);

        op(0, 1, 0, 5'd0, 32'h180, 32'h5555_AAAA, 3'b010, -1, 0, 0, 0);
        op(1, 0, 1, 5'd4, 32'h184, 0, 3'b010, 0, -1, 32'h1, 0);
        op(1, 0, 1, 5'd6, 32'h188, 0, 3'b010, -1, 0, 32'h1, 1);
        op(0, 1, 0, 5'd0, 32'h18C, 32'h0F0F_0F0F, 3'b010, T - 1, 0, 0, 0);
        wbq.push_back({5'd10, 32'hFFFF_FF9A});
        op(1, 0, 1, 5'd10, 32'h191, 0, 3'b000, T - 1, T - 1, 32'h1234_9A78, 1);

        if (!TRAP) wbq.push_back({5'd11, 32'h1122_3344});
        op(1, 0, 1, 5'd11, 32'h102, 0, 3'b010, 0, 0, 32'h1122_3344, 0);
        chk("lw_mis_be", cap_be, TRAP ? 4'h0 : 4'hF);
        chk("lw_mis_adr", cap_adr, TRAP ? 30'h0 : 30'h40);

        @(posedge clk); #1;
        cmd_ld_ma = 1'b1; cmd_st_ma = 1'b0; wbk_rd_reg_ma = 1'b1; rd_adr_ma = 5'd12;
        rd_data_ma = 32'h200; ldst_code_ma = 3'b010; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        exp_adr = 30'h80; exp_be = 4'hF; exp_we = 1'b0; bus_on = 1'b0;
        @(posedge clk); #1;
        bus_on = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b0;
        bus_on = 1'b0;
        #1;
        chk("rst_mid_req", dmem_req, 1'b0);
        cmd_ld_ma = 1'b0; wbk_rd_reg_ma = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        for (int ci = 0; ci < 6; ci++) begin
            for (int o = 0; o < 4; o++) begin
                c = 3'(ci);
                a = 32'h300 + 32'(o) + 32'(ci * 16);
                r = $urandom;
                if (!(TRAP && m_mis(c, a))) wbq.push_back({5'(ci * 4 + o + 1), m_load(r, a, c)});
                op(1, 0, 1, 5'(ci * 4 + o + 1), a, 0, c, o % 2, (ci + o) % 3, r, o == 3);
            end
        end
        for (int ci = 0; ci < 3; ci++) begin
            for (int o = 0; o < 4; o++) begin
                op(0, 1, 1, 5'd1, 32'h400 + 32'(o), $urandom, 3'(ci), o % 3, 0, 0, 0);
            end
        end

        idle(3);
        chk("wbq_empty", 64'(wbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
